// File: rtl/jpeg_soc_pkg.sv
// Shared constants and types for the JPEG SoC dual-port RAM and its port-2 drain.
package jpeg_soc_pkg;

    localparam int unsigned ADDROFFSET = 206800;
    localparam int unsigned CTRL_ADDR  = 411698;
    localparam int unsigned LEN_ADDR   = 411699;
    localparam int unsigned BUF_FULL   = 1;
    localparam int unsigned BUF_FREE   = 0;
    localparam int unsigned BUF_DEPTH  = 1200;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        FETCH,
        SEND,
        RELEASE
    } drain_state_t;

endpackage

// File: rtl/word_unpacker.sv
// Holds one fetched 32-bit RAM word and presents it little-endian, one byte at a time.
module word_unpacker (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        advance_i,
    output logic [7:0]  byte_o,
    output logic        last_of_word_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  byte_sel_q, byte_sel_d;

    // A load restarts at byte 0; an accepted byte steps to the next lane, otherwise the byte is held.
    always_comb begin
        word_d     = word_q;
        byte_sel_d = byte_sel_q;
        if (load_i) begin
            word_d     = word_i;
            byte_sel_d = 2'd0;
        end else if (advance_i) begin
            byte_sel_d = byte_sel_q + 2'd1;
        end
    end

    // Word and lane registers, cleared so the output byte reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            byte_sel_q <= 2'd0;
        end else begin
            word_q     <= word_d;
            byte_sel_q <= byte_sel_d;
        end
    end

    assign byte_o         = word_q[{byte_sel_q, 3'b000} +: 8];
    assign last_of_word_o = (byte_sel_q == 2'd3);

endmodule

// File: rtl/jpeg_stream_drain.sv
// Port-2 consumer of the shared frame RAM: waits for a full buffer, streams its bytes
// out over valid/ready, then hands the buffer back to the CPU by clearing the status word.
module jpeg_stream_drain
    import jpeg_soc_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = jpeg_soc_pkg::BUF_DEPTH,
    parameter int unsigned ADDROFFSET = jpeg_soc_pkg::ADDROFFSET,
    parameter int unsigned CTRL_ADDR  = jpeg_soc_pkg::CTRL_ADDR,
    parameter int unsigned LEN_ADDR   = jpeg_soc_pkg::LEN_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] wdata,
    output logic             enw,
    input  logic [WIDTH-1:0] rdata,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [WIDTH-1:0] MAX_BYTES = WIDTH'(DEPTH * 4);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    drain_state_t     state_q, state_d;
    logic [WIDTH-1:0] word_idx_q, word_idx_d;
    logic [WIDTH-1:0] bytes_left_q, bytes_left_d;

    logic unpack_load;
    logic unpack_advance;
    logic unpack_last_of_word;

    assign unpack_load    = (state_q == FETCH);
    assign unpack_advance = (state_q == SEND) && m_ready;

    word_unpacker u_unpacker (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (unpack_load),
        .word_i         (rdata[31:0]),
        .advance_i      (unpack_advance),
        .byte_o         (m_data),
        .last_of_word_o (unpack_last_of_word)
    );

    // Next-state, counter updates and RAM/stream outputs, all decoded from registered state
    // so the RAM port sees a stable address and write strobe for the whole slow cycle.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        bytes_left_d = bytes_left_q;
        address      = WIDTH'(CTRL_ADDR);
        wdata        = '0;
        enw          = 1'b0;
        frame_done   = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        busy         = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (enable && (rdata == WIDTH'(BUF_FULL))) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                address      = WIDTH'(LEN_ADDR);
                bytes_left_d = (rdata > MAX_BYTES) ? MAX_BYTES : rdata;
                word_idx_d   = '0;
                state_d      = (rdata == '0) ? RELEASE : FETCH;
            end
            FETCH: begin
                address    = WIDTH'(ADDROFFSET) + word_idx_q;
                word_idx_d = word_idx_q + ONE;
                state_d    = SEND;
            end
            SEND: begin
                m_valid = 1'b1;
                m_last  = (bytes_left_q == ONE);
                if (m_ready) begin
                    bytes_left_d = bytes_left_q - ONE;
                    if (bytes_left_q == ONE) begin
                        state_d = RELEASE;
                    end else if (unpack_last_of_word) begin
                        state_d = FETCH;
                    end
                end
            end
            RELEASE: begin
                wdata      = WIDTH'(BUF_FREE);
                enw        = 1'b1;
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and frame counters; reset abandons any frame in flight without touching the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            bytes_left_q <= '0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            bytes_left_q <= bytes_left_d;
        end
    end

endmodule

// File: tb/tb_jpeg_stream_drain.sv
// Bench for jpeg_stream_drain: behavioural RAM, frame-level byte scoreboard and release monitor.
module tb_jpeg_stream_drain;
    import jpeg_soc_pkg::*;

    localparam int DEPTH = 1200;
    localparam int MAXB  = DEPTH * 4;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_byte_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] address, wdata, rdata;
    logic        enw;
    logic [7:0]  m_data;
    logic        m_valid, m_last, busy, frame_done;

    logic [31:0] bufMem [DEPTH];
    logic [31:0] ctrlWord = 32'd0;
    logic [31:0] lenWord = 32'd0;
    logic        cpuArm = 1'b0;

    exp_byte_t   expQ [$];
    int          nChecks = 0;
    int          nPass = 0;
    int          relExpected = 0;
    int          relCount = 0;
    int          framesIssued = 0;
    int          readyMode = 0;
    int          readyPhase = 0;
    logic [31:0] maxFetch = 32'd0;
    logic        holdPending = 1'b0;
    logic [8:0]  holdValue = 9'd0;

    jpeg_stream_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .address    (address),
        .wdata      (wdata),
        .enw        (enw),
        .rdata      (rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Combinational RAM read port: status word, length word and the frame buffer.
    always_comb begin
        if (address == CTRL_ADDR)
            rdata = ctrlWord;
        else if (address == LEN_ADDR)
            rdata = lenWord;
        else if (address >= ADDROFFSET && address < ADDROFFSET + DEPTH)
            rdata = bufMem[int'(address - ADDROFFSET)];
        else
            rdata = 32'hDEAD_BEEF;
    end

    // RAM write side: the drain clears the status word, the CPU arms it.
    always @(posedge clk) begin
        if (enw && address == CTRL_ADDR)
            ctrlWord <= wdata;
        else if (cpuArm)
            ctrlWord <= 32'd1;
    end

    // Sink ready generator: tied high, the 1,0,0,1 pattern, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (readyPhase % 4 == 0) || (readyPhase % 4 == 3);
                    readyPhase++;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp)
            nPass++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Expected bytes of a frame: clamped length, little-endian bytes of consecutive words.
    task automatic pushExpected(input int len);
        int n;
        logic [31:0] w;
        exp_byte_t e;
        n = (len > MAXB) ? MAXB : len;
        for (int i = 0; i < n; i++) begin
            w = bufMem[i / 4];
            e.d = w[8 * (i % 4) +: 8];
            e.l = (i == n - 1);
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int len, input int mode, input bit randomFill);
        int words;
        if (randomFill) begin
            words = (((len > MAXB) ? MAXB : len) + 3) / 4;
            for (int i = 0; i < words; i++)
                bufMem[i] = $urandom;
        end
        lenWord   = len;
        readyMode = mode;
        maxFetch  = 32'd0;
        pushExpected(len);
        relExpected++;
        framesIssued++;
        cpuArm = 1'b1;
        @(posedge clk);
        #1;
        cpuArm = 1'b0;
    endtask

    task automatic measureLatency(input int expCycles);
        int k;
        k = 0;
        @(negedge clk);
        while (!(m_valid || enw) && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("start_latency", k, expCycles);
    endtask

    task automatic waitRelease(input int budget);
        int k;
        k = 0;
        while (relCount < framesIssued && k < budget) begin
            @(posedge clk);
            k++;
        end
        checkOutput("release_in_time", 32'(relCount >= framesIssued), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 32'd0);
        checkOutput("status_freed", ctrlWord, 32'd0);
        checkOutput("idle_after_release", busy, 32'd0);
    endtask

    // Monitor: scoreboard pops on every handshake, hold stability under backpressure, release strobes.
    always @(negedge clk) begin
        exp_byte_t e;
        if (!rst_n) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("hold_valid", m_valid, 32'd1);
                checkOutput("hold_data_last", {m_last, m_data}, holdValue);
            end
            holdPending = m_valid && !m_ready;
            holdValue   = {m_last, m_data};
            if (m_valid && m_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_byte", {m_last, m_data}, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("byte_data", m_data, e.d);
                    checkOutput("byte_last", m_last, e.l);
                end
            end
            if (enw || frame_done) begin
                checkOutput("release_addr", address, CTRL_ADDR);
                checkOutput("release_wdata", wdata, 32'd0);
                checkOutput("release_strobes", {enw, frame_done}, 32'd3);
                checkOutput("release_expected", 32'(relExpected > 0), 32'd1);
                checkOutput("release_bytes_done", expQ.size(), 32'd0);
                relExpected--;
                relCount++;
            end
            if (busy && address >= ADDROFFSET && address < ADDROFFSET + DEPTH && address > maxFetch)
                maxFetch = address;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_address", address, CTRL_ADDR);
        checkOutput("rst_wdata", wdata, 32'd0);
        checkOutput("rst_enw", enw, 32'd0);
        checkOutput("rst_valid", m_valid, 32'd0);
        checkOutput("rst_last", m_last, 32'd0);
        checkOutput("rst_data", m_data, 32'd0);
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_done", frame_done, 32'd0);
        rst_n = 1'b1;

        // Polling with the buffer free.
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("poll_address", address, CTRL_ADDR);
            checkOutput("poll_enw", enw, 32'd0);
            checkOutput("poll_valid", m_valid, 32'd0);
            checkOutput("poll_busy", busy, 32'd0);
        end
        @(posedge clk);
        #1;

        // Six-byte frame, sink always ready.
        bufMem[0] = 32'h4433_2211;
        bufMem[1] = 32'h0000_6655;
        applyStimulus(6, 0, 1'b0);
        measureLatency(3);
        waitRelease(100);

        // Same frame with 1,0,0,1 backpressure.
        applyStimulus(6, 1, 1'b0);
        waitRelease(200);

        // Empty frame releases straight from the length read.
        applyStimulus(0, 0, 1'b0);
        measureLatency(2);
        waitRelease(50);

        // Exactly one word.
        applyStimulus(4, 0, 1'b1);
        measureLatency(3);
        waitRelease(50);
        checkOutput("len4_last_word_addr", maxFetch, ADDROFFSET);

        // Oversized length is clamped to the buffer.
        applyStimulus(5000, 0, 1'b1);
        waitRelease(8000);
        checkOutput("clamp_last_word_addr", maxFetch, 32'd207999);

        // Random lengths with random backpressure.
        for (int f = 0; f < 6; f++) begin
            applyStimulus(int'($urandom_range(1, 64)), 2, 1'b1);
            waitRelease(1000);
        end

        // Enable low blocks a full buffer; dropping it mid-frame does not stop the frame.
        enable = 1'b0;
        applyStimulus(10, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("gated_busy", busy, 32'd0);
            checkOutput("gated_valid", m_valid, 32'd0);
        end
        checkOutput("gated_status_kept", ctrlWord, 32'd1);
        @(posedge clk);
        #1;
        enable = 1'b1;
        k = 0;
        while (!m_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("gated_started", m_valid, 32'd1);
        enable = 1'b0;
        waitRelease(100);
        enable = 1'b1;

        // Reset in the middle of streaming: no status write, restart from word 0.
        applyStimulus(40, 0, 1'b1);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_address", address, CTRL_ADDR);
        checkOutput("midrst_enw", enw, 32'd0);
        checkOutput("midrst_valid", m_valid, 32'd0);
        checkOutput("midrst_last", m_last, 32'd0);
        checkOutput("midrst_data", m_data, 32'd0);
        checkOutput("midrst_busy", busy, 32'd0);
        checkOutput("midrst_done", frame_done, 32'd0);
        expQ.delete();
        pushExpected(40);
        @(posedge clk);
        #1;
        checkOutput("midrst_status_kept", ctrlWord, 32'd1);
        rst_n = 1'b1;
        waitRelease(500);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
